mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Control FSM that sequences a shared-memory, multi-cycle MIPS datapath (single ALU, single memory port, IR/A/B/ALUOut registers).
- Replaces the single-cycle combinational controller; emits per-state datapath enables and muxes.
- Waits on a memory-ready handshake and raises a sticky fault if memory stalls too long.

Parameters:
- TIMEOUT, 255, max consecutive cycles to wait for MemReady in a memory state before Fault (1..65535).
- CNT_W, 16, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Opcode  input  6  IR[31:26], valid from DECODE onward.
- Funct  input  6  IR[5:0].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- PCWr  output  1  unconditional PC write.
- PCWrCond  output  1  PC write if Zero (beq).
- IorD  output  1  memory address: 0 PC, 1 ALUOut.
- MemRd  output  1  memory read request.
- MemWr  output  1  memory write request.
- IRWr  output  1  instruction register load.
- RegDst  output  1  write address: 0 rt, 1 rd.
- Mem2Reg  output  1  write data: 0 ALUOut, 1 MDR.
- RegWr  output  1  register file write.
- ALUSrcA  output  1  0 PC, 1 A.
- ALUSrcB  output  2  00 B, 01 const 4, 10 signext, 11 signext<<2.
- ALUCtr  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- InstrDone  output  1  one-cycle pulse when an instruction retires.
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode/funct.
- Fault  output  1  sticky memory-timeout flag.

Behaviour:
- Reset: async to IDLE, wait counter 0, Fault 0. All outputs 0 in IDLE. IDLE goes to FETCH next cycle.
- Outputs are decoded from the state register; PCWr, IRWr, RegWr and MemWr are additionally gated by MemReady where noted.
- Supported opcodes:
  - R-type 000000, with Funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States and transitions:
  - FETCH: MemRd, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtr=ADD, PCSrc=00. IRWr and PCWr only when MemReady. MemReady goes to DECODE, else stay.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtr=ADD (branch target into ALUOut). Next state by opcode:
    - lw/sw: MEMADR. R-type: EXEC. addi: ADDI_EX. beq: BRANCH. j: JUMP.
    - Other opcode, or R-type with unknown Funct: IllegalOp pulse, then FETCH.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD: MemRd, IorD=1; on MemReady go to MEMWB.
  - MEMWB: RegWr, RegDst=0, Mem2Reg=1, InstrDone; then FETCH.
  - MEMWR: MemWr, IorD=1; on MemReady pulse InstrDone and go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtr from Funct; then RTYPE_WB.
  - RTYPE_WB: RegWr, RegDst=1, Mem2Reg=0, InstrDone; then FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ADD; then ADDI_WB.
  - ADDI_WB: RegWr, RegDst=0, Mem2Reg=0, InstrDone; then FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCWrCond, PCSrc=01, InstrDone; then FETCH.
  - JUMP: PCWr, PCSrc=10, InstrDone; then FETCH.
  - HALT: all outputs 0, Fault=1; leave only by Reset.
- Latency with MemReady=1 (FETCH to FETCH): beq/j 3 cycles, R-type/addi/sw 4 cycles, lw 5 cycles.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while MemReady=0; clears on MemReady or any state change.
  - When the counter equals TIMEOUT with MemReady still 0, go to HALT; Fault sets next edge.
  - MemReady arriving on the same cycle the counter reaches TIMEOUT counts as success; no fault.
- Reset asserted mid-instruction: immediate return to IDLE and all outputs 0; no partial RegWr or MemWr completes.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings (4-bit);
  - opcode and Funct constants;
  - ALUCtr codes;
  - ALUSrcB and PCSrc select encodings.
- One sub-module, mc_alu_dec: combinational Funct-to-ALUCtr decode plus a valid flag. Used in DECODE for the illegal check and in EXEC for ALUCtr.

Test Plan:
- Reset, then MemReady=1, Opcode=000000, Funct=100000 -> all outputs 0 in the IDLE cycle; FETCH (PCWr=1, IRWr=1), DECODE, EXEC (ALUCtr=0010), RTYPE_WB (RegWr=1, RegDst=1); InstrDone on cycle 4 after FETCH.
- lw with MemReady held 0 for 3 cycles in MEMRD -> MemRd=1, IorD=1 held 4 cycles; MEMWB RegWr=1, Mem2Reg=1; total 8 cycles.
- beq with Zero=1, then Zero=0 -> BRANCH shows PCWrCond=1, PCSrc=01, ALUCtr=0110 both times; 3-cycle loop each.
- Opcode=111111, then R-type Funct=000000 -> IllegalOp pulses once in DECODE each time; FETCH follows; no RegWr or MemWr.
- TIMEOUT=4, MemReady=0 forever in FETCH -> HALT after 4 wait cycles, Fault=1 sticky, all other outputs 0; Reset clears Fault.
- Reset pulsed during MEMWR with MemReady=0 -> MemWr drops immediately (async); IDLE then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS controller:
//   - 4-bit FSM state encoding
//   - opcode / Funct constants for the supported instruction subset
//   - ALUCtr codes, ALUSrcB and PCSrc select encodings
//   - the bundled control-word struct driven by the FSM
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMRD    = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWR    = 4'd6,
        ST_EXEC     = 4'd7,
        ST_RTYPE_WB = 4'd8,
        ST_ADDI_EX  = 4'd9,
        ST_ADDI_WB  = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_HALT     = 4'd13
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type Funct field (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Per-state datapath control word
    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_dst;
        logic       mem2reg;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctr;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // States that hold a memory access open and therefore count wait cycles
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Signal bundle between the multi-cycle controller and its datapath.
//   master : the controller (drives control/enable outputs, reads status)
//   slave  : the datapath   (drives Opcode/Funct/Zero/MemReady, reads controls)
// -----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;

    // Datapath status towards the controller
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;

    // Controls towards the datapath
    logic       PCWr;
    logic       PCWrCond;
    logic       IorD;
    logic       MemRd;
    logic       MemWr;
    logic       IRWr;
    logic       RegDst;
    logic       Mem2Reg;
    logic       RegWr;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUCtr;
    logic [1:0] PCSrc;
    logic       InstrDone;
    logic       IllegalOp;
    logic       Fault;

    modport master (
        input  Opcode, Funct, Zero, MemReady,
        output PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, Mem2Reg,
               RegWr, ALUSrcA, ALUSrcB, ALUCtr, PCSrc, InstrDone, IllegalOp,
               Fault
    );

    modport slave (
        output Opcode, Funct, Zero, MemReady,
        input  PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, Mem2Reg,
               RegWr, ALUSrcA, ALUSrcB, ALUCtr, PCSrc, InstrDone, IllegalOp,
               Fault
    );

endinterface

// File: rtl/mc_alu_dec.sv
// -----------------------------------------------------------------------------
// mc_alu_dec
// Combinational R-type Funct decoder.
//   funct_i   : IR[5:0]
//   alu_ctr_o : ALU operation for the Funct value (ADD when unsupported)
//   valid_o   : 1 when Funct is one of add/sub/and/or/slt
// -----------------------------------------------------------------------------
module mc_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctr_o,
    output logic       valid_o
);

    // Funct to ALU operation lookup
    always_comb begin
        alu_ctr_o = ALU_ADD;
        valid_o   = 1'b0;
        case (funct_i)
            FN_ADD: begin alu_ctr_o = ALU_ADD; valid_o = 1'b1; end
            FN_SUB: begin alu_ctr_o = ALU_SUB; valid_o = 1'b1; end
            FN_AND: begin alu_ctr_o = ALU_AND; valid_o = 1'b1; end
            FN_OR:  begin alu_ctr_o = ALU_OR;  valid_o = 1'b1; end
            FN_SLT: begin alu_ctr_o = ALU_SLT; valid_o = 1'b1; end
            default: begin
                alu_ctr_o = ALU_ADD;
                valid_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Control FSM for a shared-memory multi-cycle MIPS datapath.
//   Clk   : rising-edge clock
//   Reset : asynchronous, active-high; forces IDLE, clears wait counter/Fault
//   bus   : master side of mips_multicycle_ctrl_if
//           in : Opcode, Funct, Zero, MemReady
//           out: PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, Mem2Reg,
//                RegWr, ALUSrcA, ALUSrcB, ALUCtr, PCSrc, InstrDone,
//                IllegalOp, Fault
// Controls are decoded from the current state; FETCH qualifies PCWr/IRWr
// with MemReady and MEMWR retires only once memory accepts the write.
// A memory state that waits TIMEOUT cycles and still sees no MemReady
// parks the FSM in HALT with a sticky Fault until Reset.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               fault_q;
    logic               fault_d;
    ctrl_t              ctl_s;
    logic [3:0]         fn_alu_s;
    logic               fn_valid_s;
    logic               timeout_s;

    mc_alu_dec u_alu_dec (
        .funct_i   (bus.Funct),
        .alu_ctr_o (fn_alu_s),
        .valid_o   (fn_valid_s)
    );

    // A stalled access has used its whole budget when the counter hits TIMEOUT
    assign timeout_s = (cnt_q == TIMEOUT_C);

    // State register, wait counter and sticky fault
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d = state_q;
        ctl_s   = '0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ctl_s.mem_rd    = 1'b1;
                ctl_s.i_or_d    = 1'b0;
                ctl_s.alu_src_a = 1'b0;
                ctl_s.alu_src_b = SRCB_FOUR;
                ctl_s.alu_ctr   = ALU_ADD;
                ctl_s.pc_src    = PCSRC_ALU;
                if (bus.MemReady) begin
                    ctl_s.ir_wr = 1'b1;
                    ctl_s.pc_wr = 1'b1;
                    state_d     = ST_DECODE;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // ALUOut captures PC+4 + (signext<<2) as the beq target
                ctl_s.alu_src_a = 1'b0;
                ctl_s.alu_src_b = SRCB_IMM_SH2;
                ctl_s.alu_ctr   = ALU_ADD;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_RTYPE: begin
                        if (fn_valid_s) begin
                            state_d = ST_EXEC;
                        end else begin
                            ctl_s.illegal_op = 1'b1;
                            state_d          = ST_FETCH;
                        end
                    end
                    default: begin
                        ctl_s.illegal_op = 1'b1;
                        state_d          = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ctl_s.alu_src_a = 1'b1;
                ctl_s.alu_src_b = SRCB_IMM;
                ctl_s.alu_ctr   = ALU_ADD;
                if (bus.Opcode == OP_SW) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMRD: begin
                ctl_s.mem_rd = 1'b1;
                ctl_s.i_or_d = 1'b1;
                if (bus.MemReady) begin
                    state_d = ST_MEMWB;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWB: begin
                ctl_s.reg_wr     = 1'b1;
                ctl_s.reg_dst    = 1'b0;
                ctl_s.mem2reg    = 1'b1;
                ctl_s.instr_done = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_MEMWR: begin
                ctl_s.mem_wr = 1'b1;
                ctl_s.i_or_d = 1'b1;
                if (bus.MemReady) begin
                    ctl_s.instr_done = 1'b1;
                    state_d          = ST_FETCH;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_EXEC: begin
                ctl_s.alu_src_a = 1'b1;
                ctl_s.alu_src_b = SRCB_REG;
                ctl_s.alu_ctr   = fn_alu_s;
                state_d         = ST_RTYPE_WB;
            end
            ST_RTYPE_WB: begin
                ctl_s.reg_wr     = 1'b1;
                ctl_s.reg_dst    = 1'b1;
                ctl_s.mem2reg    = 1'b0;
                ctl_s.instr_done = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_ADDI_EX: begin
                ctl_s.alu_src_a = 1'b1;
                ctl_s.alu_src_b = SRCB_IMM;
                ctl_s.alu_ctr   = ALU_ADD;
                state_d         = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                ctl_s.reg_wr     = 1'b1;
                ctl_s.reg_dst    = 1'b0;
                ctl_s.mem2reg    = 1'b0;
                ctl_s.instr_done = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_BRANCH: begin
                // The datapath qualifies PCWrCond with Zero
                ctl_s.alu_src_a  = 1'b1;
                ctl_s.alu_src_b  = SRCB_REG;
                ctl_s.alu_ctr    = ALU_SUB;
                ctl_s.pc_wr_cond = 1'b1;
                ctl_s.pc_src     = PCSRC_ALUOUT;
                ctl_s.instr_done = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_JUMP: begin
                ctl_s.pc_wr      = 1'b1;
                ctl_s.pc_src     = PCSRC_JUMP;
                ctl_s.instr_done = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Wait counter: counts only while a memory state keeps stalling, else clears
    always_comb begin
        if (is_wait_state(state_q) && !bus.MemReady && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Fault latches on entry to HALT and holds until Reset
    always_comb begin
        if (state_d == ST_HALT) begin
            fault_d = 1'b1;
        end else begin
            fault_d = fault_q;
        end
    end

    assign bus.PCWr      = ctl_s.pc_wr;
    assign bus.PCWrCond  = ctl_s.pc_wr_cond;
    assign bus.IorD      = ctl_s.i_or_d;
    assign bus.MemRd     = ctl_s.mem_rd;
    assign bus.MemWr     = ctl_s.mem_wr;
    assign bus.IRWr      = ctl_s.ir_wr;
    assign bus.RegDst    = ctl_s.reg_dst;
    assign bus.Mem2Reg   = ctl_s.mem2reg;
    assign bus.RegWr     = ctl_s.reg_wr;
    assign bus.ALUSrcA   = ctl_s.alu_src_a;
    assign bus.ALUSrcB   = ctl_s.alu_src_b;
    assign bus.ALUCtr    = ctl_s.alu_ctr;
    assign bus.PCSrc     = ctl_s.pc_src;
    assign bus.InstrDone = ctl_s.instr_done;
    assign bus.IllegalOp = ctl_s.illegal_op;
    assign bus.Fault     = fault_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed scenarios with hand-computed expectations, then randomized
// instruction/MemReady/Reset traffic checked every cycle against a
// step-plan model of the controller.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int TMO = 4;

    logic Clk;
    logic Reset;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    typedef struct packed {
        logic       pcwr;
        logic       pcwrcond;
        logic       iord;
        logic       memrd;
        logic       memwr;
        logic       irwr;
        logic       regdst;
        logic       mem2reg;
        logic       regwr;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] aluctr;
        logic [1:0] pcsrc;
        logic       done;
        logic       illegal;
        logic       fault;
    } outs_t;

    // Abstract steps an instruction walks through
    typedef enum {M_IDLE, M_FETCH, M_DECODE, M_ADDR, M_LOAD, M_LOADWB, M_STORE,
                  M_RALU, M_RWB, M_IALU, M_IWB, M_BR, M_JMP, M_HALT} mstep_t;

    mstep_t m_step = M_IDLE;
    mstep_t m_plan[$];
    int     m_wait = 0;
    int     n_vec  = 0;
    int     n_err  = 0;

    function automatic int alu_code(logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic logic legal(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: return alu_code(fn) >= 0;
            6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t expect_outs(mstep_t s, logic [5:0] op, logic [5:0] fn, logic mr);
        outs_t o;
        int    a;
        o = '0;
        a = alu_code(fn);
        case (s)
            M_FETCH:  begin o.memrd = 1'b1; o.srcb = 2'b01; o.aluctr = 4'b0010;
                            o.irwr = mr; o.pcwr = mr; end
            M_DECODE: begin o.srcb = 2'b11; o.aluctr = 4'b0010; o.illegal = !legal(op, fn); end
            M_ADDR, M_IALU: begin o.srca = 1'b1; o.srcb = 2'b10; o.aluctr = 4'b0010; end
            M_LOAD:   begin o.memrd = 1'b1; o.iord = 1'b1; end
            M_LOADWB: begin o.regwr = 1'b1; o.mem2reg = 1'b1; o.done = 1'b1; end
            M_STORE:  begin o.memwr = 1'b1; o.iord = 1'b1; o.done = mr; end
            M_RALU:   begin o.srca = 1'b1; o.srcb = 2'b00; o.aluctr = a[3:0]; end
            M_RWB:    begin o.regwr = 1'b1; o.regdst = 1'b1; o.done = 1'b1; end
            M_IWB:    begin o.regwr = 1'b1; o.done = 1'b1; end
            M_BR:     begin o.srca = 1'b1; o.srcb = 2'b00; o.aluctr = 4'b0110;
                            o.pcwrcond = 1'b1; o.pcsrc = 2'b01; o.done = 1'b1; end
            M_JMP:    begin o.pcwr = 1'b1; o.pcsrc = 2'b10; o.done = 1'b1; end
            M_HALT:   begin o.fault = 1'b1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.pcwr = bus.PCWr;       o.pcwrcond = bus.PCWrCond; o.iord = bus.IorD;
        o.memrd = bus.MemRd;     o.memwr = bus.MemWr;       o.irwr = bus.IRWr;
        o.regdst = bus.RegDst;   o.mem2reg = bus.Mem2Reg;   o.regwr = bus.RegWr;
        o.srca = bus.ALUSrcA;    o.srcb = bus.ALUSrcB;      o.aluctr = bus.ALUCtr;
        o.pcsrc = bus.PCSrc;     o.done = bus.InstrDone;    o.illegal = bus.IllegalOp;
        o.fault = bus.Fault;
        return o;
    endfunction

    function automatic logic [31:0] vec32(outs_t o);
        return {11'd0, o};
    endfunction

    // Remaining steps of the instruction just fetched
    task automatic build_plan();
        case (bus.Opcode)
            6'b100011: m_plan = '{M_DECODE, M_ADDR, M_LOAD, M_LOADWB};
            6'b101011: m_plan = '{M_DECODE, M_ADDR, M_STORE};
            6'b001000: m_plan = '{M_DECODE, M_IALU, M_IWB};
            6'b000100: m_plan = '{M_DECODE, M_BR};
            6'b000010: m_plan = '{M_DECODE, M_JMP};
            6'b000000: begin
                if (alu_code(bus.Funct) >= 0) m_plan = '{M_DECODE, M_RALU, M_RWB};
                else                          m_plan = '{M_DECODE};
            end
            default:   m_plan = '{M_DECODE};
        endcase
    endtask

    task automatic go_next();
        m_wait = 0;
        if (m_plan.size() > 0) m_step = m_plan.pop_front();
        else                   m_step = M_FETCH;
    endtask

    task automatic model_advance();
        if (Reset) begin
            m_step = M_IDLE;
            m_plan.delete();
            m_wait = 0;
        end else begin
            case (m_step)
                M_IDLE: m_step = M_FETCH;
                M_HALT: m_step = M_HALT;
                M_FETCH, M_LOAD, M_STORE: begin
                    if (bus.MemReady) begin
                        if (m_step == M_FETCH) build_plan();
                        go_next();
                    end else if (m_wait == TMO) begin
                        m_step = M_HALT;
                        m_wait = 0;
                    end else begin
                        m_wait = m_wait + 1;
                    end
                end
                default: go_next();
            endcase
        end
    endtask

    // Per-cycle compare against the model, then step the model across the edge
    always @(negedge Clk) begin
        outs_t e;
        outs_t a;
        e = Reset ? '0 : expect_outs(m_step, bus.Opcode, bus.Funct, bus.MemReady);
        a = dut_outs();
        n_vec = n_vec + 1;
        if (a !== e) begin
            n_err = n_err + 1;
            $display("FAIL cycle_cmp t=%0t step=%s got=%h expected=%h", $time, m_step.name(), a, e);
        end
        model_advance();
    end

    task automatic pin(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch_pin(string nm);
        pin(nm, {28'd0, bus.MemRd, bus.IorD, bus.ALUSrcB}, 32'd9);
    endtask

    task automatic pick_instr();
        int r;
        logic [5:0] fns [5];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        r = $urandom_range(0, 15);
        bus.Funct = 6'($urandom_range(0, 63));
        if (r <= 3)       begin bus.Opcode = 6'b000000; bus.Funct = fns[$urandom_range(0, 4)]; end
        else if (r == 4)  bus.Opcode = 6'b000000;
        else if (r <= 6)  bus.Opcode = 6'b100011;
        else if (r <= 8)  bus.Opcode = 6'b101011;
        else if (r <= 10) bus.Opcode = 6'b000100;
        else if (r == 11) bus.Opcode = 6'b000010;
        else if (r <= 13) bus.Opcode = 6'b001000;
        else              bus.Opcode = 6'($urandom_range(0, 63));
    endtask

    initial begin
        outs_t halt_v;
        halt_v = '0;
        halt_v.fault = 1'b1;

        Reset = 1'b1;
        bus.Opcode = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        pin("reset_all_zero", vec32(dut_outs()), 32'd0);

        // R-type add, MemReady=1: IDLE, FETCH, DECODE, EXEC, RTYPE_WB
        Reset = 1'b0; bus.MemReady = 1'b1; bus.Opcode = 6'b000000; bus.Funct = 6'b100000;
        #2 pin("idle_all_zero", vec32(dut_outs()), 32'd0);
        nxt();
        #2 pin("fetch_pcwr_irwr", {30'd0, bus.PCWr, bus.IRWr}, 32'd3);
        nxt(); nxt();
        #2 pin("exec_aluctr_add", {28'd0, bus.ALUCtr}, 32'd2);
        nxt();
        #2 pin("rwb_regwr_regdst_done", {29'd0, bus.RegWr, bus.RegDst, bus.InstrDone}, 32'd7);
        nxt();

        // lw with three stall cycles in MEMRD: 8 cycles FETCH to FETCH
        bus.Opcode = 6'b100011;
        for (int c = 0; c < 8; c++) begin
            bus.MemReady = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #2;
            if (c == 0) fetch_pin("lw_fetch");
            if (c >= 3 && c <= 6) pin("lw_memrd_iord", {30'd0, bus.MemRd, bus.IorD}, 32'd3);
            if (c == 7) pin("lw_wb", {29'd0, bus.RegWr, bus.Mem2Reg, bus.InstrDone}, 32'd7);
            nxt();
        end

        // beq taken and not taken: identical 3-cycle control sequence
        for (int z = 1; z >= 0; z--) begin
            bus.Opcode = 6'b000100; bus.Zero = 1'(z); bus.MemReady = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #2;
                if (c == 0) fetch_pin("beq_fetch");
                if (c == 2) pin("beq_branch",
                    {24'd0, bus.PCWrCond, bus.PCSrc, bus.ALUCtr, bus.InstrDone}, 32'hAD);
                nxt();
            end
        end

        // Unsupported opcode, then R-type with unknown Funct
        for (int k = 0; k < 2; k++) begin
            bus.Opcode = (k == 0) ? 6'b111111 : 6'b000000;
            bus.Funct  = 6'b000000;
            for (int c = 0; c < 2; c++) begin
                #2;
                if (c == 0) fetch_pin("illegal_fetch");
                if (c == 1) pin("illegal_pulse", {29'd0, bus.IllegalOp, bus.RegWr, bus.MemWr}, 32'd4);
                nxt();
            end
        end

        // MemReady arrives exactly when the counter reaches TIMEOUT: no fault
        bus.Opcode = 6'b000010;
        for (int c = 0; c < 7; c++) begin
            bus.MemReady = (c < 4) ? 1'b0 : 1'b1;
            #2;
            if (c == 0) fetch_pin("edge_fetch");
            if (c == 4) pin("edge_irwr_nofault", {30'd0, bus.IRWr, bus.Fault}, 32'd2);
            if (c == 6) pin("edge_jump", {29'd0, bus.PCWr, bus.PCSrc}, 32'd6);
            nxt();
        end

        // MemReady never comes: HALT with sticky Fault, cleared by Reset
        bus.MemReady = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) bus.MemReady = 1'b1;
            #2;
            if (c == 0) fetch_pin("tmo_fetch");
            if (c == 4) pin("tmo_last_wait", {30'd0, bus.MemRd, bus.Fault}, 32'd2);
            if (c >= 5) pin("tmo_halt_vec", vec32(dut_outs()), vec32(halt_v));
            nxt();
        end
        Reset = 1'b1;
        #2 pin("tmo_reset_clears", vec32(dut_outs()), 32'd0);
        nxt();
        Reset = 1'b0;
        nxt();

        // sw stalled in MEMWR, Reset pulsed mid-cycle
        bus.Opcode = 6'b101011; bus.MemReady = 1'b1;
        #2 fetch_pin("sw_fetch");
        nxt(); nxt(); nxt();
        bus.MemReady = 1'b0;
        #2 pin("sw_memwr", {31'd0, bus.MemWr}, 32'd1);
        #1 Reset = 1'b1;
        #1 pin("sw_async_drop", vec32(dut_outs()), 32'd0);
        nxt();
        Reset = 1'b0;
        #2 pin("sw_idle", vec32(dut_outs()), 32'd0);
        nxt();
        #2 fetch_pin("sw_refetch");
        nxt();

        // Randomized traffic, model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            Reset = (m_step == M_HALT || $urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            bus.MemReady = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            bus.Zero     = 1'($urandom_range(0, 1));
            if (m_step == M_FETCH || m_step == M_IDLE) pick_instr();
            nxt();
        end

        Reset = 1'b0;
        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
